// File: rtl/riscv_hpc_reader.sv
// riscv_hpc_reader: snapshot-based reader for the six instruction-type HPC counters
// Ports:
//   clk, rst_i                 clock and synchronous active-high reset
//   cnt_rtype..cnt_jtype       live counter values, indices 0..5
//   req_valid/req_ready/req_addr   read request: 0..5 single, DUMP_ADDR all six, else illegal
//   rsp_valid/rsp_ready        response beat handshake
//   rsp_data/rsp_idx/rsp_last/rsp_err   beat payload
//   busy                       a response is in progress
module riscv_hpc_reader #(
    parameter int         CNT_W     = 32,
    parameter logic [2:0] DUMP_ADDR = 3'd7
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] cnt_rtype,
    input  logic [CNT_W-1:0] cnt_itype,
    input  logic [CNT_W-1:0] cnt_stype,
    input  logic [CNT_W-1:0] cnt_btype,
    input  logic [CNT_W-1:0] cnt_utype,
    input  logic [CNT_W-1:0] cnt_jtype,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] rsp_data,
    output logic [2:0]       rsp_idx,
    output logic             rsp_last,
    output logic             rsp_err,
    output logic             busy
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] snap_q [6];
    logic [CNT_W-1:0] cnt_in [6];
    logic             rsp_valid_q;
    logic [CNT_W-1:0] rsp_data_q;
    logic [2:0]       rsp_idx_q;
    logic             rsp_last_q;
    logic             rsp_err_q;
    logic             is_dump;
    logic             is_single;
    logic [2:0]       idx_d;

    assign cnt_in[0] = cnt_rtype;
    assign cnt_in[1] = cnt_itype;
    assign cnt_in[2] = cnt_stype;
    assign cnt_in[3] = cnt_btype;
    assign cnt_in[4] = cnt_utype;
    assign cnt_in[5] = cnt_jtype;

    // dump decode wins if DUMP_ADDR is ever set inside the single-read range
    assign is_dump   = req_addr == DUMP_ADDR;
    assign is_single = !is_dump && req_addr < 3'd6;
    assign idx_d     = rsp_idx_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_idx_q   <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < 6; i++) snap_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    // first beat is loaded straight from the live inputs, which equal the snapshot being captured
                    snap_q      <= cnt_in;
                    state_q     <= SEND;
                    rsp_valid_q <= 1'b1;
                    rsp_idx_q   <= is_dump ? 3'd0 : req_addr;
                    rsp_data_q  <= is_dump ? cnt_in[0] : is_single ? cnt_in[req_addr] : '0;
                    rsp_last_q  <= !is_dump;
                    rsp_err_q   <= !is_dump && !is_single;
                end
                SEND: if (rsp_ready) begin
                    if (rsp_last_q) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end else begin
                        rsp_idx_q  <= idx_d;
                        rsp_data_q <= snap_q[idx_d];
                        rsp_last_q <= idx_d == 3'd5;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = state_q == IDLE;
    assign busy      = state_q == SEND;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
endmodule
